// File: rtl/frida_seq_ctrl_if.sv
// frida_seq_ctrl_if: sequencer <-> control bank / ADC array signal bundle.
//   start, cont, comp_in          : requests and comparator decision into the sequencer
//   seq_init/samp/cmp/logic       : phase strobes shared by the ADC array
//   busy, result, result_valid    : conversion status and last completed result
//   modport slave  : the sequencer side
//   modport master : the control bank / array side
interface frida_seq_ctrl_if #(
    parameter int NBITS = 12
);
    logic             start;
    logic             cont;
    logic             comp_in;
    logic             seq_init;
    logic             seq_samp;
    logic             seq_cmp;
    logic             seq_logic;
    logic             busy;
    logic             result_valid;
    logic [NBITS-1:0] result;

    modport slave (
        input  start, cont, comp_in,
        output seq_init, seq_samp, seq_cmp, seq_logic, busy, result, result_valid
    );

    modport master (
        output start, cont, comp_in,
        input  seq_init, seq_samp, seq_cmp, seq_logic, busy, result, result_valid
    );
endinterface

// File: rtl/frida_seq_ctrl.sv
// frida_seq_ctrl: self-timed SAR conversion sequencer for the FRIDA ADC array.
//   clk, rst : sequencer clock (rising edge), synchronous active-high reset
//   bus      : frida_seq_ctrl_if.slave (start/cont/comp_in in; strobes, busy,
//              result, result_valid out)
//   Optional macro FRIDA_SEQ_CONT_EN enables free-running conversions via cont.
module frida_seq_ctrl #(
    parameter int NBITS   = 12,
    parameter int T_INIT  = 2,
    parameter int T_SAMP  = 4,
    parameter int T_CMP   = 1,
    parameter int T_LOGIC = 1
) (
    input logic              clk,
    input logic              rst,
    frida_seq_ctrl_if.slave  bus
);
    localparam int TM1  = T_INIT > T_SAMP ? T_INIT : T_SAMP;
    localparam int TM2  = T_CMP > T_LOGIC ? T_CMP : T_LOGIC;
    localparam int TMAX = TM1 > TM2 ? TM1 : TM2;
    localparam int CW   = TMAX > 1 ? $clog2(TMAX) : 1;
    localparam int BW   = NBITS > 1 ? $clog2(NBITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SAMP,
        S_CMP,
        S_LOGIC,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [BW-1:0]    bit_q;
    logic [NBITS-1:0] shadow_q;
    logic [NBITS-1:0] result_q;
    logic             go;
    logic             again;

`ifdef FRIDA_SEQ_CONT_EN
    assign go    = bus.start | bus.cont;
    assign again = bus.cont;
`else
    logic unused_cont;
    assign unused_cont = bus.cont;
    assign go          = bus.start;
    assign again       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shadow_q <= '0;
            result_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: if (go) begin
                    state_q  <= S_INIT;
                    cnt_q    <= CW'(T_INIT - 1);
                    shadow_q <= '0;
                end
                S_INIT: if (cnt_q == '0) begin
                    state_q <= S_SAMP;
                    cnt_q   <= CW'(T_SAMP - 1);
                end else cnt_q <= cnt_q - 1'b1;
                S_SAMP: if (cnt_q == '0) begin
                    state_q <= S_CMP;
                    cnt_q   <= CW'(T_CMP - 1);
                    bit_q   <= BW'(NBITS - 1);
                end else cnt_q <= cnt_q - 1'b1;
                // comparator is only trusted on the final compare cycle
                S_CMP: if (cnt_q == '0) begin
                    shadow_q[bit_q] <= bus.comp_in;
                    state_q         <= S_LOGIC;
                    cnt_q           <= CW'(T_LOGIC - 1);
                end else cnt_q <= cnt_q - 1'b1;
                // result loads on DONE entry so it changes with result_valid
                S_LOGIC: if (cnt_q == '0) begin
                    if (bit_q == '0) begin
                        state_q  <= S_DONE;
                        result_q <= shadow_q;
                    end else begin
                        state_q <= S_CMP;
                        bit_q   <= bit_q - 1'b1;
                        cnt_q   <= CW'(T_CMP - 1);
                    end
                end else cnt_q <= cnt_q - 1'b1;
                S_DONE: if (again) begin
                    state_q  <= S_INIT;
                    cnt_q    <= CW'(T_INIT - 1);
                    shadow_q <= '0;
                end else state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.seq_init     = state_q == S_INIT;
    assign bus.seq_samp     = state_q == S_SAMP;
    assign bus.seq_cmp      = state_q == S_CMP;
    assign bus.seq_logic    = state_q == S_LOGIC;
    assign bus.busy         = state_q != S_IDLE;
    assign bus.result_valid = state_q == S_DONE;
    assign bus.result       = result_q;
endmodule

// File: doc/frida_seq_ctrl.md
# frida_seq_ctrl

On-chip conversion sequencer for the FRIDA SAR ADC array. On each accepted start it drives the four phase strobes seq_init, seq_samp, seq_cmp and seq_logic that are shared by all 16 ADCs. It captures the muxed comparator decision once per bit cycle into a result word. It replaces external generation of the sequencing clocks when the core runs in self-timed mode, and sits between the SPI-configured control bank and the ADC array/compmux.

## Interface
- NBITS, 12: conversion bit cycles per conversion; legal 1–16.
- T_INIT, 2: clk cycles seq_init is high; legal ≥1.
- T_SAMP, 4: clk cycles seq_samp is high; legal ≥1.
- T_CMP, 1: clk cycles seq_cmp is high per bit; legal ≥1.
- T_LOGIC, 1: clk cycles seq_logic is high per bit; legal ≥1.
- clk  input  1  sequencer clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  conversion request; sampled only in IDLE.
- cont  input  1  free-run request; functional only with FRIDA_SEQ_CONT_EN.
- comp_in  input  1  comparator decision from compmux comp_out.
- seq_init  output  1  init phase strobe.
- seq_samp  output  1  sample phase strobe.
- seq_cmp  output  1  compare phase strobe.
- seq_logic  output  1  update phase strobe.
- busy  output  1  high in every state except IDLE.
- result  output  NBITS  last completed conversion, MSB first.
- result_valid  output  1  one-cycle pulse when result updates.

## Operation
- States: IDLE, INIT, SAMP, CMP, LOGIC, DONE. A phase counter counts down from T_x−1 and a bit index counts down from NBITS−1.
- IDLE → INIT when start=1.
- INIT → SAMP after T_INIT cycles.
- SAMP → CMP after T_SAMP cycles.
- CMP → LOGIC after T_CMP cycles. On the last CMP cycle, comp_in is written into shadow bit [bit index] (1 = comparator high).
- LOGIC → CMP after T_LOGIC cycles with bit index decremented, or LOGIC → DONE if bit index = 0.
- DONE lasts 1 cycle. In DONE: result ← shadow and result_valid=1. Next state is IDLE, or INIT if continuous mode is active.
- Strobes are decoded from the registered state. Exactly one strobe is high in INIT/SAMP/CMP/LOGIC. No strobe is high in IDLE or DONE, so the strobes are mutually exclusive and glitch-free.
- The shadow register is cleared on entry to INIT. result holds its value until the next DONE.
- start outside IDLE is ignored, with no queuing. This includes start asserted in the DONE cycle.
- comp_in is ignored outside the last CMP cycle of each bit.

## Timing
- Reset values: all strobes 0, busy 0, result 0, result_valid 0, state IDLE. The shadow register and counters are cleared.
- rst asserted mid-conversion: the next edge forces reset values. The partial conversion is discarded and result is overwritten with 0.
- start sampled high at edge k → seq_init high from cycle k+1.
- Conversion length from the start edge to the result_valid cycle: L = T_INIT + T_SAMP + NBITS·(T_CMP + T_LOGIC) + 1 cycles.
- result and result_valid change in the same cycle. busy falls in the cycle after DONE, or stays high in continuous mode.
- In continuous mode, back-to-back conversions have zero idle cycles: DONE is followed directly by INIT.
- Minimum IDLE dwell between single-shot conversions: 1 cycle.

## Configuration
- FRIDA_SEQ_CONT_EN defined:
  - With cont=1 sampled in DONE, the FSM goes DONE → INIT. The cont input alone also starts conversions from IDLE, as if start=1.
  - Dropping cont finishes the current conversion, then returns to IDLE.
- FRIDA_SEQ_CONT_EN undefined:
  - The cont port is present but ignored.
  - DONE always goes to IDLE, and only start launches conversions.

## Test plan
- Reset: hold rst 3 cycles with start=1 → all outputs 0, busy 0; no strobe for 2 cycles after release with start=0.
- Single shot, NBITS=4, T_INIT=2, T_SAMP=3, T_CMP=1, T_LOGIC=1, comp_in pattern per bit 1,0,1,1:
  - result_valid pulses exactly 14 cycles after the start edge, with result=4'b1011.
  - Strobe sequence: init×2, samp×3, then (cmp, logic)×4.
- Busy-ignore: re-pulse start mid-SAMP and in the DONE cycle → exactly one conversion; result_valid pulses once; IDLE dwell ≥1 cycle.
- Mid-conversion reset: assert rst during bit 2 CMP after a prior result 0xA → next cycle all strobes 0, result 0, busy 0; a fresh start then completes normally.
- comp_in toggling: toggle comp_in every cycle with T_CMP=3 → each captured bit equals comp_in on the third CMP cycle only.
- FRIDA_SEQ_CONT_EN: cont=1 from IDLE → consecutive result_valid pulses spaced 14 cycles apart (same params); drop cont mid-conversion → that conversion completes, then IDLE. Without the macro, the same stimulus produces no conversion.
